display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 40 ++++
 rtl/seg7_encode.sv | 19 +
 rtl/display_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed six-digit clock display scanner.
package display_pkg;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_t;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Element 0 is the pattern for digit 0; the concatenation is written from 9 down to 0
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } time_snap_t;

  // Tens by threshold compare, ones by subtracting tens*10 in 4-bit modular arithmetic
  function automatic logic [7:0] split_decimal(input logic [5:0] value);
    logic [3:0] tens;
    logic [3:0] ones;
    if (value >= 6'd60)      tens = 4'd6;
    else if (value >= 6'd50) tens = 4'd5;
    else if (value >= 6'd40) tens = 4'd4;
    else if (value >= 6'd30) tens = 4'd3;
    else if (value >= 6'd20) tens = 4'd2;
    else if (value >= 6'd10) tens = 4'd1;
    else                     tens = 4'd0;
    ones = value[3:0] - tens * 4'd10;
    return {tens, ones};
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Seven-segment encoder: decimal digit to segments a..g, with a dash override.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       dash,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    if (dash) begin
      segments = SEG_DASH;
    end else if (digit <= 4'd9) begin
      segments = SEG_DIGITS[digit];
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit HH:MM:SS display scanner with anti-ghosting blank gaps between digits.
// Optional macro DISPLAY_DP_BLINK_EN lights the decimal points of digits 2 and 4 on even seconds.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  output logic [5:0] digit_en,
  output logic [7:0] segment_out,
  output logic       frame_done
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

  scan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       digit_idx, digit_next;
  time_snap_t       snap, snap_next;
  logic             frame_next;
  logic [5:0]       digit_en_next;
  logic [7:0]       segment_next;
  logic [7:0]       sec_bcd, min_bcd, hr_bcd;
  logic             sec_bad, min_bad, hr_bad;
  logic [3:0]       cur_digit;
  logic             cur_dash;
  logic [6:0]       seg_bits;
  logic             dp_next;

  // Outputs are registered alongside the state so they switch on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      digit_idx   <= '0;
      snap        <= '0;
      digit_en    <= '0;
      segment_out <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      digit_idx   <= digit_next;
      snap        <= snap_next;
      digit_en    <= digit_en_next;
      segment_out <= segment_next;
      frame_done  <= frame_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    digit_next = digit_idx;
    snap_next  = snap;
    frame_next = 1'b0;
    if (!en) begin
      state_next = ST_BLANK;
      cnt_next   = '0;
      digit_next = '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_next = ST_DRIVE;
            cnt_next   = '0;
            if (digit_idx == 3'd0) begin
              snap_next = '{hours: hours, minutes: minutes, seconds: seconds};
            end
          end
        end
        default: begin
          if (cnt == DRIVE_LAST) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
            if (digit_idx == LAST_DIGIT) begin
              digit_next = '0;
              frame_next = 1'b1;
            end else begin
              digit_next = digit_idx + 3'd1;
            end
          end
        end
      endcase
    end
  end

  // Decode from the next-cycle snapshot so digit 0 shows the value captured on the same edge
  assign sec_bcd = split_decimal(snap_next.seconds);
  assign min_bcd = split_decimal(snap_next.minutes);
  assign hr_bcd  = split_decimal({1'b0, snap_next.hours});
  assign sec_bad = snap_next.seconds > 6'd59;
  assign min_bad = snap_next.minutes > 6'd59;
  assign hr_bad  = snap_next.hours > 5'd23;

  always_comb begin
    cur_digit = 4'd0;
    cur_dash  = 1'b0;
    case (digit_next)
      3'd0: begin cur_digit = sec_bcd[3:0]; cur_dash = sec_bad; end
      3'd1: begin cur_digit = sec_bcd[7:4]; cur_dash = sec_bad; end
      3'd2: begin cur_digit = min_bcd[3:0]; cur_dash = min_bad; end
      3'd3: begin cur_digit = min_bcd[7:4]; cur_dash = min_bad; end
      3'd4: begin cur_digit = hr_bcd[3:0];  cur_dash = hr_bad;  end
      default: begin cur_digit = hr_bcd[7:4]; cur_dash = hr_bad; end
    endcase
  end

  seg7_encode u_seg7 (
    .digit    (cur_digit),
    .dash     (cur_dash),
    .segments (seg_bits)
  );

`ifdef DISPLAY_DP_BLINK_EN
  assign dp_next = ((digit_next == 3'd2) || (digit_next == 3'd4)) &&
                   !snap_next.seconds[0] && !sec_bad;
`else
  assign dp_next = 1'b0;
`endif

  always_comb begin
    digit_en_next = '0;
    segment_next  = '0;
    if (state_next == ST_DRIVE) begin
      digit_en_next = 6'b000001 << digit_next;
      segment_next  = {dp_next, seg_bits};
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with a frame-position reference model.
module tb_display_scan_ctrl;

  localparam int DIG   = 4;
  localparam int BLK   = 1;
  localparam int SLOT  = DIG + BLK;
  localparam int FRAME = 6 * SLOT;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef DISPLAY_DP_BLINK_EN
  localparam logic [7:0] EXP_D2 = 8'hE6;
  localparam logic [7:0] EXP_D4 = 8'hDB;
`else
  localparam logic [7:0] EXP_D2 = 8'h66;
  localparam logic [7:0] EXP_D4 = 8'h5B;
`endif
  localparam logic [7:0] EXP_DEC   [6] = '{8'h7D, 8'h6D, EXP_D2, 8'h4F, EXP_D4, 8'h06};
  localparam logic [7:0] EXP_RANGE [6] = '{8'h6F, 8'h6D, 8'h40, 8'h40, 8'h40, 8'h40};

  logic       clk;
  logic       reset;
  logic       en;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [5:0] digit_en;
  logic [7:0] segment_out;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int p = 0;
  int snap_s = 0, snap_m = 0, snap_h = 0;
  bit model_ok = 1'b0;
  int rs, rm, rh;
  bit re, rr;

  display_scan_ctrl #(
    .DIGIT_CYCLES (DIG),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .seconds     (seconds),
    .minutes     (minutes),
    .hours       (hours),
    .digit_en    (digit_en),
    .segment_out (segment_out),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // p counts cycles since the last restart; every output follows from p and the snapshot
  always @(posedge clk) begin
    if (reset) begin
      p        <= 0;
      snap_s   <= 0;
      snap_m   <= 0;
      snap_h   <= 0;
      model_ok <= 1'b1;
    end else if (!en) begin
      p <= 0;
    end else begin
      p <= p + 1;
      if ((p + 1) % FRAME == BLK) begin
        snap_s <= int'(seconds);
        snap_m <= int'(minutes);
        snap_h <= int'(hours);
      end
    end
  end

  function automatic logic [7:0] model_seg(input int dig, input int s, input int m, input int h);
    int  field;
    bit  bad;
    logic [7:0] res;
    case (dig)
      0, 1:    begin field = s; bad = (s > 59); end
      2, 3:    begin field = m; bad = (m > 59); end
      default: begin field = h; bad = (h > 23); end
    endcase
    if (bad) res = 8'h40;
    else     res = {1'b0, SEG_TAB[(dig % 2 == 0) ? field % 10 : field / 10]};
`ifdef DISPLAY_DP_BLINK_EN
    if ((dig == 2 || dig == 4) && (s % 2 == 0) && (s <= 59)) res[7] = 1'b1;
`endif
    return res;
  endfunction

  function automatic logic [14:0] model_outputs(input int pos, input int s, input int m, input int h);
    int slot, dig, phase;
    logic [5:0] e;
    logic [7:0] g;
    logic fd;
    slot  = pos % FRAME;
    dig   = slot / SLOT;
    phase = slot % SLOT;
    e = '0;
    g = '0;
    fd = (pos >= FRAME) && (slot == 0);
    if (phase >= BLK) begin
      e = 6'(1 << dig);
      g = model_seg(dig, s, m, h);
    end
    return {e, g, fd};
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      logic [14:0] exp_v;
      exp_v = model_outputs(p, snap_s, snap_m, snap_h);
      checks++;
      if ({digit_en, segment_out, frame_done} !== exp_v) begin
        errors++;
        $display("[TB] FAIL scan p=%0d: got digit_en=%02h seg=%02h fd=%0b, expected digit_en=%02h seg=%02h fd=%0b",
                 p, digit_en, segment_out, frame_done, exp_v[14:9], exp_v[8:1], exp_v[0]);
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit e, input int s, input int m, input int h, input int n);
    reset   = r;
    en      = e;
    seconds = 6'(s);
    minutes = 6'(m);
    hours   = 5'(h);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [5:0] exp_en, input logic [7:0] exp_seg, input logic exp_fd);
    checks++;
    if (digit_en !== exp_en || segment_out !== exp_seg || frame_done !== exp_fd) begin
      errors++;
      $display("[TB] FAIL %s: got digit_en=%02h seg=%02h fd=%0b, expected digit_en=%02h seg=%02h fd=%0b",
               name, digit_en, segment_out, frame_done, exp_en, exp_seg, exp_fd);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; seconds = '0; minutes = '0; hours = '0;
    @(negedge clk);

    // 12:34:56 decode, blank gaps and frame_done period
    applyStimulus(1, 1, 56, 34, 12, 2);
    checkOutput("reset_idle", 6'h00, 8'h00, 1'b0);
    applyStimulus(0, 1, 56, 34, 12, 1);
    for (int d = 0; d < 6; d++) begin
      checkOutput($sformatf("decode_d%0d", d), 6'(1 << d), EXP_DEC[d], 1'b0);
      applyStimulus(0, 1, 56, 34, 12, 4);
      if (d < 5) checkOutput("decode_blank", 6'h00, 8'h00, 1'b0);
      else       checkOutput("frame_done_1", 6'h00, 8'h00, 1'b1);
      applyStimulus(0, 1, 56, 34, 12, 1);
    end
    applyStimulus(0, 1, 56, 34, 12, 29);
    checkOutput("frame_done_2", 6'h00, 8'h00, 1'b1);

    // Reset held three cycles in the middle of a DRIVE
    applyStimulus(0, 1, 56, 34, 12, 2);
    applyStimulus(1, 1, 56, 34, 12, 1);
    checkOutput("reset_mid_drive", 6'h00, 8'h00, 1'b0);
    applyStimulus(1, 1, 56, 34, 12, 2);
    checkOutput("reset_held", 6'h00, 8'h00, 1'b0);
    applyStimulus(0, 1, 56, 34, 12, 1);
    checkOutput("reset_first_drive", 6'h01, 8'h7D, 1'b0);

    // Out-of-range fields show dashes
    applyStimulus(1, 1, 59, 60, 24, 1);
    applyStimulus(0, 1, 59, 60, 24, 1);
    for (int d = 0; d < 6; d++) begin
      checkOutput($sformatf("range_d%0d", d), 6'(1 << d), EXP_RANGE[d], 1'b0);
      applyStimulus(0, 1, 59, 60, 24, 5);
    end

    // Seconds change mid-frame must not tear the frame
    applyStimulus(1, 1, 56, 34, 12, 1);
    applyStimulus(0, 1, 56, 34, 12, 16);
    checkOutput("snap_d3", 6'h08, 8'h4F, 1'b0);
    applyStimulus(0, 1, 57, 34, 12, 5);
    checkOutput("snap_d4", 6'h10, EXP_D4, 1'b0);
    applyStimulus(0, 1, 57, 34, 12, 5);
    checkOutput("snap_d5", 6'h20, 8'h06, 1'b0);
    applyStimulus(0, 1, 57, 34, 12, 5);
    checkOutput("snap_next_d0", 6'h01, 8'h07, 1'b0);
    applyStimulus(0, 1, 57, 34, 12, 10);
    checkOutput("snap_next_d2", 6'h04, 8'h66, 1'b0);

    // Enable dropped during digit 2, then restored
    applyStimulus(1, 1, 56, 34, 12, 1);
    applyStimulus(0, 1, 56, 34, 12, 12);
    checkOutput("en_d2", 6'h04, EXP_D2, 1'b0);
    applyStimulus(0, 0, 56, 34, 12, 1);
    checkOutput("en_off", 6'h00, 8'h00, 1'b0);
    applyStimulus(0, 0, 56, 34, 12, 3);
    checkOutput("en_off_hold", 6'h00, 8'h00, 1'b0);
    applyStimulus(0, 1, 56, 34, 12, 1);
    checkOutput("en_restart", 6'h01, 8'h7D, 1'b0);

    // Randomized traffic, checked every cycle by the model
    rs = 56; rm = 34; rh = 12; re = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 79) == 0) re = ~re;
      if (!re && $urandom_range(0, 3) == 0) re = 1'b1;
      if ($urandom_range(0, 14) == 0) begin
        rs = $urandom_range(0, 63);
        rm = $urandom_range(0, 63);
        rh = $urandom_range(0, 31);
      end
      applyStimulus(rr, re, rs, rm, rh, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
